// File: rtl/regfile_write_port_pkg.sv
// Shared constants, FSM encoding and slice helper for the register-file write port.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_write_port_pkg;

  // Register file geometry
  localparam int RF_WIDTH  = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREGS  = 32;

  // Write-port controller states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Low bit of register idx inside the flattened register image
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_write_port_decoder5to32.sv
// Address-to-one-hot decoder shared by the commit path and the clear sweep.
// Latency: combinational, zero cycles.
// Backpressure: none; output is all zeros when i_en is low.
module decoder5to32
  import regfile_write_port_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NOUT   = RF_NREGS
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_en,
  output logic [NOUT-1:0]   o_onehot
);

  // One bit per output line, only the addressed line may be high
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NOUT; i++) begin
      o_onehot[i] = i_en && (i_addr == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32x32 register file: one-entry pending buffer, commit, clear sweep.
// Latency: accept at edge N, data visible on o_regs_flat and o_wr_ack high after edge N+1.
// Backpressure: o_wr_ready low during a sweep, while i_clear_req is high, or when pending and held.
module regfile_write_port
  import regfile_write_port_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREGS  = RF_NREGS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic                   o_wr_ack,
  input  logic                   i_hold,
  input  logic                   i_clear_req,
  output logic                   o_clear_busy,
  output logic                   o_clear_done,
  output logic [NREGS*WIDTH-1:0] o_regs_flat
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);

  // Controller state
  state_t            r_state;
  state_t            w_state_nxt;

  // One-entry pending write buffer
  logic              r_pend_v;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [WIDTH-1:0]  r_pend_dat;

  // Clear sweep position (next register to zero)
  logic [ADDR_W-1:0] r_clr_idx;

  // Registered pulses
  logic              r_wr_ack;
  logic              r_clear_done;

  // Storage for registers 1..NREGS-1; register 0 is a constant zero
  logic [WIDTH-1:0]  r_regs [1:NREGS-1];

  // Datapath / control wires
  logic              w_wr_ready;
  logic              w_accept;
  logic              w_commit;
  logic              w_clr_step;
  logic              w_clr_last;
  logic              w_dec_en;
  logic [ADDR_W-1:0] w_dec_addr;
  logic [NREGS-1:0]  w_dec_oh;
  logic [WIDTH-1:0]  w_wr_dat;
  logic              w_unused_dec0;

  // Handshake and event qualification
  always_comb begin
    w_wr_ready = (r_state == ST_IDLE) && !i_clear_req && (!r_pend_v || !i_hold);
    w_accept   = i_wr_valid && w_wr_ready;
    w_commit   = r_pend_v && !i_hold && (r_state == ST_IDLE);
    w_clr_step = (r_state == ST_CLEAR) && !i_hold;
    w_clr_last = w_clr_step && (r_clr_idx == LAST_IDX);
  end

  // Shared decoder input: the sweep index owns the decoder while clearing
  always_comb begin
    w_dec_addr = (r_state == ST_CLEAR) ? r_clr_idx : r_pend_addr;
    w_dec_en   = w_commit || w_clr_step;
    w_wr_dat   = w_clr_step ? '0 : r_pend_dat;
  end

  decoder5to32 #(
    .ADDR_W (ADDR_W),
    .NOUT   (NREGS)
  ) u_dec (
    .i_addr   (w_dec_addr),
    .i_en     (w_dec_en),
    .o_onehot (w_dec_oh)
  );

  // Line 0 of the decoder has no storage behind it, so addr-0 writes vanish
  assign w_unused_dec0 = w_dec_oh[0];

  // Next-state logic: enter the sweep only once no write is pending
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_clear_req && !r_pend_v) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (w_clr_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending buffer: a same-edge accept refills the slot being committed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_pend_dat  <= '0;
    end else if (w_accept) begin
      r_pend_v    <= 1'b1;
      r_pend_addr <= i_wr_addr;
      r_pend_dat  <= i_wr_data;
    end else if (w_commit) begin
      r_pend_v    <= 1'b0;
    end
  end

  // Sweep index advances on every unheld sweep edge and wraps back to 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr_idx <= FIRST_IDX;
    end else if (w_clr_step) begin
      r_clr_idx <= w_clr_last ? FIRST_IDX : (r_clr_idx + ADDR_W'(1));
    end
  end

  // Completion pulses, one cycle after the committing / final sweep edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ack     <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_wr_ack     <= w_commit;
      r_clear_done <= w_clr_last;
    end
  end

  // Storage update through the one-hot enables
  always_ff @(posedge clk) begin
    for (int i = 1; i < NREGS; i++) begin
      if (!rst_n) begin
        r_regs[i] <= '0;
      end else if (w_dec_oh[i]) begin
        r_regs[i] <= w_wr_dat;
      end
    end
  end

  // Flattened register image
  assign o_regs_flat[slice_lo(0, WIDTH) +: WIDTH] = '0;
  for (genvar g = 1; g < NREGS; g++) begin : g_flat
    assign o_regs_flat[slice_lo(g, WIDTH) +: WIDTH] = r_regs[g];
  end

  assign o_wr_ready   = w_wr_ready;
  assign o_wr_ack     = r_wr_ack;
  assign o_clear_busy = (r_state == ST_CLEAR);
  assign o_clear_done = r_clear_done;

endmodule
